// File: rtl/tt_10_ef6404_nand_exerciser_if.sv
// Pin bundle between the NAND exerciser tile and the gate it drives.
// Latency: none, wires only.
// Backpressure: none; plain level signals, no handshake.
interface tt_10_ef6404_nand_exerciser_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Tile side: reads the dedicated and bidirectional inputs, drives the outputs.
    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    // Harness side: the mirror image of the tile.
    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );
endinterface

// File: rtl/tt_10_ef6404_nand_exerciser.sv
// Drives all four A/B vectors into a 2-input NAND, samples Y and flags mismatches.
// Latency: start edge to busy = SYNC_STAGES+1 clocks; one run = 4*(SETTLE_CYCLES+2) clocks.
// Backpressure: none; start pulses while busy are dropped, continuous mode rearms after one DONE cycle.
module tt_10_ef6404_nand_exerciser #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_10_ef6404_nand_exerciser_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    logic [2:0]             state;
    logic [1:0]             idx;
    logic [7:0]             settle_cnt;
    logic                   drv_a;
    logic                   drv_b;
    logic [3:0]             fail_mask;
    logic                   done_r;
    logic                   pass_r;
    logic                   fail_sticky;

    logic [SYNC_STAGES-1:0] start_sync;
    logic [SYNC_STAGES-1:0] y_sync;
    logic                   start_prev;
    logic                   start_pulse;

    logic                   y_src;
    logic                   y_meas;
    logic                   y_exp;
    logic                   mismatch;
    logic [3:0]             mask_next;
    logic                   busy;
    logic                   cont_mode;
    logic                   loopback;
    logic                   fault_inj;
    logic                   unused_in;

    assign cont_mode = bus.ui_in[1];
    assign loopback  = bus.ui_in[2];
    assign fault_inj = bus.ui_in[3];

    // Loopback and external Y share one synchronizer so both paths see identical timing.
    assign y_src  = loopback ? ~(drv_a & drv_b) : bus.uio_in[2];
    assign y_meas = y_sync[SYNC_STAGES-1];

    // Rising edge of the synchronized start input.
    assign start_pulse = start_sync[SYNC_STAGES-1] & ~start_prev;

    // Synchronizer chains for the two asynchronous inputs, plus the edge-detect history bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= '0;
            y_sync     <= '0;
            start_prev <= 1'b0;
        end else begin
            start_sync[0] <= bus.ui_in[0];
            y_sync[0]     <= y_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                start_sync[i] <= start_sync[i-1];
                y_sync[i]     <= y_sync[i-1];
            end
            start_prev <= start_sync[SYNC_STAGES-1];
        end
    end

    // Expected response for the vector currently held, and the mask after this sample.
    always_comb begin
        y_exp     = ~(drv_a & drv_b) ^ fault_inj;
        mismatch  = (y_meas != y_exp);
        mask_next = fail_mask;
        if (mismatch) begin
            mask_next = fail_mask | (4'b0001 << idx);
        end
    end

    // Sequencer: DRIVE -> SETTLE -> SAMPLE per vector, four vectors per run, then DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            settle_cnt  <= 8'd0;
            drv_a       <= 1'b0;
            drv_b       <= 1'b0;
            fail_mask   <= 4'd0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_sticky <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state       <= ST_DRIVE;
                        idx         <= 2'd0;
                        fail_mask   <= 4'd0;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_sticky <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    drv_a      <= idx[0];
                    drv_b      <= idx[1];
                    settle_cnt <= SETTLE_LD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt <= 8'd1) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    fail_mask <= mask_next;
                    if (mismatch) begin
                        fail_sticky <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                        pass_r <= (mask_next == 4'd0);
                        drv_a  <= 1'b0;
                        drv_b  <= 1'b0;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    // Continuous mode keeps the sticky flag across runs; a fresh start clears it.
                    if (cont_mode) begin
                        state     <= ST_DRIVE;
                        idx       <= 2'd0;
                        fail_mask <= 4'd0;
                        done_r    <= 1'b0;
                        pass_r    <= 1'b0;
                    end else if (start_pulse) begin
                        state       <= ST_DRIVE;
                        idx         <= 2'd0;
                        fail_mask   <= 4'd0;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_sticky <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);

    assign bus.uo_out  = {fail_mask, fail_sticky, pass_r, done_r, busy};
    assign bus.uio_out = {6'b000000, drv_b, drv_a};
    assign bus.uio_oe  = 8'b0000_0011;

    // Tile enable and spare pins are intentionally not used.
    assign unused_in = &{1'b0, bus.ena, bus.ui_in[7:4], bus.uio_in[7:3], bus.uio_in[1:0]};

endmodule

// File: tb/tb_tt_10_ef6404_nand_exerciser.sv
// Self-checking bench for the NAND exerciser: per-cycle model comparison plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_tt_10_ef6404_nand_exerciser;

    localparam int S   = 4;
    localparam int VEC = S + 2;
    localparam int RUN = 4 * VEC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tt_10_ef6404_nand_exerciser_if bus ();

    tt_10_ef6404_nand_exerciser #(
        .SETTLE_CYCLES(S),
        .SYNC_STAGES  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 = idle, 1 = running (k = cycles since first DRIVE), 2 = done
    int         m_mode  = 0;
    int         m_k     = 0;
    logic [3:0] m_fails = 4'd0;
    logic       m_base  = 1'b0;
    logic [2:0] m_hist  = 3'd0;

    function automatic logic [3:0] calc_fails(input logic lb, input logic flt, input logic ext);
        logic [3:0] f;
        f = 4'd0;
        for (int i = 0; i < 4; i++) begin
            logic nand_v;
            logic y;
            nand_v = !((i % 2 == 1) && (i / 2 == 1));
            y      = lb ? nand_v : ext;
            f[i]   = (y != (nand_v ^ flt));
        end
        return f;
    endfunction

    // Advance the model across each rising edge using the inputs present at that edge.
    always @(posedge clk) begin
        logic pulse;
        logic go;
        if (!rst_n) begin
            m_mode  = 0;
            m_k     = 0;
            m_fails = 4'd0;
            m_base  = 1'b0;
            m_hist  = 3'd0;
        end else begin
            pulse  = m_hist[1] & ~m_hist[2];
            m_hist = {m_hist[1:0], bus.ui_in[0]};
            go     = 1'b0;
            if (m_mode == 1) begin
                m_k++;
                if (m_k == RUN) m_mode = 2;
            end else if (m_mode == 2 && bus.ui_in[1]) begin
                m_base = m_base | (|m_fails);
                go     = 1'b1;
            end else if (pulse) begin
                m_base = 1'b0;
                go     = 1'b1;
            end
            if (go) begin
                m_mode  = 1;
                m_k     = 0;
                m_fails = calc_fails(bus.ui_in[2], bus.ui_in[3], bus.uio_in[2]);
            end
        end
    end

    // Compare every output on every falling edge.
    always @(negedge clk) begin
        logic [7:0] e_uo;
        logic [7:0] e_uio;
        logic [3:0] vis;
        int         v;
        int         p;
        int         ab_v;
        e_uo  = 8'd0;
        e_uio = 8'd0;
        if (m_mode == 1) begin
            v   = m_k / VEC;
            p   = m_k % VEC;
            vis = 4'd0;
            for (int i = 0; i < 4; i++) begin
                if (m_k >= (i + 1) * VEC) vis[i] = m_fails[i];
            end
            e_uo  = {vis, m_base | (|vis), 1'b0, 1'b0, 1'b1};
            ab_v  = (p == 0) ? ((v == 0) ? 0 : v - 1) : v;
            e_uio = 8'(ab_v);
        end else if (m_mode == 2) begin
            e_uo = {m_fails, m_base | (|m_fails), (m_fails == 4'd0), 1'b1, 1'b0};
        end
        chk("uo_out", {24'd0, bus.uo_out}, {24'd0, e_uo});
        chk("uio_out", {24'd0, bus.uio_out}, {24'd0, e_uio});
        chk("uio_oe", {24'd0, bus.uio_oe}, 32'h03);
    end

    // ---------------- stimulus ----------------
    int ab [0:255];

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic start, input logic cont, input logic lb,
                         input logic flt, input logic ext);
        bus.ui_in  = {4'b0000, flt, lb, cont, start};
        bus.uio_in = {5'b00000, ext, 2'b00};
    endtask

    // Wait (bounded) for busy, then count busy cycles recording A/B per offset.
    // pa >= 0 re-pulses start mid-run at offset pa.
    task automatic measure(input int pa, output int len);
        int t;
        t = 0;
        while (!bus.uo_out[0] && t < 40) begin
            cyc(1);
            t++;
        end
        chk("busy_rise", {31'd0, bus.uo_out[0]}, 32'd1);
        len = 0;
        while (bus.uo_out[0] && len < 200) begin
            ab[len] = int'(bus.uio_out[1:0]);
            if (len == pa)     bus.ui_in[0] = 1'b0;
            if (len == pa + 2) bus.ui_in[0] = 1'b1;
            len++;
            cyc(1);
        end
    endtask

    initial begin
        int len;
        int g;
        int c;
        bus.ena = 1'b1;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(3);
        chk("rst_uo", {24'd0, bus.uo_out}, 32'h00);
        chk("rst_uio", {24'd0, bus.uio_out}, 32'h00);
        rst_n = 1'b1;
        cyc(2);

        // Loopback, no fault: clean pass, A/B stepping at VEC spacing.
        drive(1, 0, 1, 0, 0);
        measure(-1, len);
        chk("t1_len", len, 24);
        chk("t1_ab1", ab[1], 0);
        chk("t1_ab6", ab[6], 0);
        chk("t1_ab7", ab[7], 1);
        chk("t1_ab13", ab[13], 2);
        chk("t1_ab19", ab[19], 3);
        chk("t1_uo", {24'd0, bus.uo_out}, 32'h06);
        cyc(10);
        chk("t1_hold_one_run", {24'd0, bus.uo_out}, 32'h06);

        // Loopback with inverted expectation: every vector fails.
        drive(0, 0, 1, 1, 0);
        cyc(3);
        drive(1, 0, 1, 1, 0);
        measure(-1, len);
        chk("t2_uo", {24'd0, bus.uo_out}, 32'hFA);

        // External Y stuck high: only vector 3 fails.
        drive(0, 0, 0, 0, 1);
        cyc(3);
        drive(1, 0, 0, 0, 1);
        measure(-1, len);
        chk("t3_uo", {24'd0, bus.uo_out}, 32'h8A);

        // Continuous mode: one DONE cycle between runs, then drop mode mid-run.
        drive(0, 0, 1, 0, 0);
        cyc(3);
        drive(1, 1, 1, 0, 0);
        measure(-1, len);
        chk("t4_len1", len, 24);
        g = 0;
        while (!bus.uo_out[0] && g < 10) begin
            g++;
            cyc(1);
        end
        chk("t4_gap", g, 1);
        chk("t4_redrive", {24'd0, bus.uio_out}, 32'h00);
        cyc(5);
        bus.ui_in[1] = 1'b0;
        c = 0;
        while (bus.uo_out[0] && c < 60) begin
            c++;
            cyc(1);
        end
        chk("t4_len2", c, RUN - 5);
        cyc(8);
        chk("t4_done_hold", {30'd0, bus.uo_out[1:0]}, 32'h2);

        // Start re-pulsed while busy is ignored.
        drive(0, 0, 1, 0, 0);
        cyc(3);
        drive(1, 0, 1, 0, 0);
        measure(3, len);
        chk("t6_len", len, 24);
        cyc(10);
        chk("t6_no_restart", {31'd0, bus.uo_out[0]}, 32'd0);

        // Asynchronous reset during SETTLE of vector 2.
        drive(0, 0, 1, 0, 0);
        cyc(3);
        drive(1, 0, 1, 0, 0);
        g = 0;
        while (!bus.uo_out[0] && g < 40) begin
            g++;
            cyc(1);
        end
        cyc(14);
        chk("t5_pre_uio", {24'd0, bus.uio_out}, 32'h02);
        rst_n = 1'b0;
        #1;
        chk("t5_async_uo", {24'd0, bus.uo_out}, 32'h00);
        chk("t5_async_uio", {24'd0, bus.uio_out}, 32'h00);
        drive(0, 0, 1, 0, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("t5_stay_idle", {24'd0, bus.uo_out}, 32'h00);
        drive(1, 0, 1, 0, 0);
        measure(-1, len);
        chk("t5_rerun_len", len, 24);

        // Randomized runs checked by the model every cycle.
        for (int r = 0; r < 14; r++) begin
            logic lb;
            logic flt;
            logic ext;
            logic cont;
            int   pa;
            lb   = 1'($urandom_range(0, 1));
            flt  = 1'($urandom_range(0, 1));
            ext  = 1'($urandom_range(0, 1));
            cont = ($urandom_range(0, 3) == 0);
            pa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            drive(0, 0, lb, flt, ext);
            cyc(3);
            drive(1, cont, lb, flt, ext);
            measure(pa, len);
            chk("rnd_len", len, 24);
            if (cont) begin
                cyc(int'($urandom_range(2, 20)));
                bus.ui_in[1] = 1'b0;
                c = 0;
                while (bus.uo_out[0] && c < 60) begin
                    c++;
                    cyc(1);
                end
                chk("rnd_cont_end", {31'd0, bus.uo_out[0]}, 32'd0);
            end
            cyc(int'($urandom_range(1, 4)));
        end

        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
